// File: rtl/ex_muldiv_pkg.sv
// Shared encodings for the EX-stage RV32M multiply/divide unit.
// Holds the M-extension opcode fields and the control FSM state type.
package ex_muldiv_pkg;

   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

   localparam logic [2:0] FUNCT3_MUL    = 3'b000;
   localparam logic [2:0] FUNCT3_MULH   = 3'b001;
   localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
   localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
   localparam logic [2:0] FUNCT3_DIV    = 3'b100;
   localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
   localparam logic [2:0] FUNCT3_REM    = 3'b110;
   localparam logic [2:0] FUNCT3_REMU   = 3'b111;

   typedef enum logic [2:0] {
      MdIdle    = 3'd0,
      MdMul     = 3'd1,
      MdDivInit = 3'd2,
      MdDivIter = 3'd3,
      MdDivFix  = 3'd4,
      MdDone    = 3'd5
   } md_state_e;

endpackage

// File: rtl/muldiv_divider.sv
// Unsigned restoring divider core: one quotient bit per cycle after a load.
// The sign fix-up and special cases are handled by the caller.
module muldiv_divider #(
   parameter int unsigned Width = 32,
   parameter int unsigned Steps = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic             abort,
   input  logic [Width-1:0] dividend,
   input  logic [Width-1:0] divisor,
   output logic [Width-1:0] quotient,
   output logic [Width-1:0] remainder,
   output logic             last
);

   localparam int unsigned CntW = (Steps > 1) ? $clog2(Steps) : 1;

   logic [Width:0]   rem_q, rem_d;
   logic [Width-1:0] quo_q, quo_d;
   logic [Width-1:0] dvs_q;
   logic [CntW-1:0]  cnt_q;
   logic             active_q;
   logic [Width+1:0] shifted;
   logic [Width+1:0] diff;
   logic             borrow;

   // Quotient bits shift into the low end of quo_q as dividend bits leave the top.
   always_comb begin
      shifted = {rem_q, quo_q[Width-1]};
      diff    = shifted - {2'b00, dvs_q};
      borrow  = diff[Width+1];
      rem_d   = borrow ? shifted[Width:0] : diff[Width:0];
      quo_d   = {quo_q[Width-2:0], ~borrow};
   end

   assign last      = active_q & (cnt_q == CntW'(Steps - 1));
   assign quotient  = quo_q;
   assign remainder = rem_q[Width-1:0];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rem_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         cnt_q    <= '0;
         active_q <= 1'b0;
      end else if (abort) begin
         active_q <= 1'b0;
      end else if (load) begin
         rem_q    <= '0;
         quo_q    <= dividend;
         dvs_q    <= divisor;
         cnt_q    <= '0;
         active_q <= 1'b1;
      end else if (active_q) begin
         rem_q <= rem_d;
         quo_q <= quo_d;
         cnt_q <= cnt_q + 1'b1;
         if (last) active_q <= 1'b0;
      end
   end

endmodule

// File: rtl/ex_muldiv.sv
// RV32M multiply/divide unit beside the EX-stage ALU: 2-cycle multiply,
// iterative radix-2 divide, with a combinational stall request.
module ex_muldiv
   import ex_muldiv_pkg::*;
#(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned DIV_STEPS = 32
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            start,
   input  logic            flush,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   md_state_e        state_q, state_d;
   logic [2:0]       op_q;
   logic [XLEN-1:0]  a_q, b_q;
   logic             quot_neg_q, rem_neg_q;
   logic [XLEN-1:0]  result_q, result_d;
   logic             accept;

   logic             a_sext, b_sext;
   logic [2*XLEN-1:0] ext_a, ext_b, product;

   logic             div_signed, div_zero, div_ovf;
   logic [XLEN-1:0]  a_abs, b_abs;
   logic             div_load, div_last;
   logic [XLEN-1:0]  div_quo, div_rem, quo_fix, rem_fix;

   assign accept = (state_q == MdIdle) & start & ~flush;

   // Full-width extension makes the low 2*XLEN product bits equal the signed product.
   always_comb begin
      a_sext  = a_q[XLEN-1] & ((op_q == FUNCT3_MULH) | (op_q == FUNCT3_MULHSU));
      b_sext  = b_q[XLEN-1] & (op_q == FUNCT3_MULH);
      ext_a   = {{XLEN{a_sext}}, a_q};
      ext_b   = {{XLEN{b_sext}}, b_q};
      product = ext_a * ext_b;
   end

   always_comb begin
      div_signed = ~op_q[0];
      div_zero   = (b_q == '0);
      div_ovf    = div_signed & (a_q == {1'b1, {(XLEN-1){1'b0}}}) & (b_q == '1);
      a_abs      = (div_signed & a_q[XLEN-1]) ? -a_q : a_q;
      b_abs      = (div_signed & b_q[XLEN-1]) ? -b_q : b_q;
      quo_fix    = quot_neg_q ? -div_quo : div_quo;
      rem_fix    = rem_neg_q ? -div_rem : div_rem;
   end

   muldiv_divider #(
      .Width (XLEN),
      .Steps (DIV_STEPS)
   ) u_divider (
      .clock     (clock),
      .reset     (reset),
      .load      (div_load),
      .abort     (flush),
      .dividend  (a_abs),
      .divisor   (b_abs),
      .quotient  (div_quo),
      .remainder (div_rem),
      .last      (div_last)
   );

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      div_load = 1'b0;
      unique case (state_q)
         MdIdle: begin
            if (start) state_d = funct3[2] ? MdDivInit : MdMul;
         end
         MdMul: begin
            result_d = (op_q == FUNCT3_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
            state_d  = MdDone;
         end
         MdDivInit: begin
            if (div_zero) begin
               result_d = op_q[1] ? a_q : '1;
               state_d  = MdDone;
            end else if (div_ovf) begin
               result_d = op_q[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
               state_d  = MdDone;
            end else begin
               div_load = 1'b1;
               state_d  = MdDivIter;
            end
         end
         MdDivIter: begin
            if (div_last) state_d = MdDivFix;
         end
         MdDivFix: begin
            result_d = op_q[1] ? rem_fix : quo_fix;
            state_d  = MdDone;
         end
         MdDone: begin
            state_d = MdIdle;
         end
         default: begin
            state_d = MdIdle;
         end
      endcase
      // Flush discards the operation entirely, including any pending result.
      if (flush) begin
         state_d  = MdIdle;
         result_d = result_q;
         div_load = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= MdIdle;
         op_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         quot_neg_q <= 1'b0;
         rem_neg_q  <= 1'b0;
         result_q   <= '0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         if (accept) begin
            op_q <= funct3;
            a_q  <= rs1;
            b_q  <= rs2;
         end
         if (state_q == MdDivInit) begin
            quot_neg_q <= div_signed & (a_q[XLEN-1] ^ b_q[XLEN-1]);
            rem_neg_q  <= div_signed & a_q[XLEN-1];
         end
      end
   end

   assign busy   = accept | (state_q == MdMul) | (state_q == MdDivInit) |
                   (state_q == MdDivIter) | (state_q == MdDivFix);
   assign done   = (state_q == MdDone);
   assign result = result_q;

   a_state_legal: assert property (@(posedge clock) disable iff (!reset)
      state_q inside {MdIdle, MdMul, MdDivInit, MdDivIter, MdDivFix, MdDone});
   a_done_not_busy: assert property (@(posedge clock) disable iff (!reset) done |-> !busy);

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: vector table, hand-written corner sequences
// and random operations against a behavioural reference, via a result queue.
module tb_ex_muldiv;
   import ex_muldiv_pkg::*;

   logic        clock  = 1'b0;
   logic        reset  = 1'b0;
   logic        start  = 1'b0;
   logic        flush  = 1'b0;
   logic [2:0]  funct3 = '0;
   logic [31:0] rs1    = '0;
   logic [31:0] rs2    = '0;
   logic        busy, done;
   logic [31:0] result;

   int          n_vec = 0;
   int          n_bad = 0;
   logic [31:0] exp_q[$];

   typedef struct {
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
   } vec_t;
   vec_t tbl[$];

   always #5 clock = ~clock;

   ex_muldiv #(
      .XLEN      (32),
      .DIV_STEPS (32)
   ) dut (
      .clock  (clock),
      .reset  (reset),
      .start  (start),
      .flush  (flush),
      .funct3 (funct3),
      .rs1    (rs1),
      .rs2    (rs2),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
      longint          sa, sb;
      longint unsigned ua, ub;
      logic [63:0]     p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      p  = '0;
      case (f)
         3'b000: begin p = ua * ub;            return p[31:0];  end
         3'b001: begin p = sa * sb;            return p[63:32]; end
         3'b010: begin p = sa * longint'(ub);  return p[63:32]; end
         3'b011: begin p = ua * ub;            return p[63:32]; end
         3'b100: begin
            if (b == 0) return 32'hFFFF_FFFF;
            p = sa / sb;
            return p[31:0];
         end
         3'b101: begin
            if (b == 0) return 32'hFFFF_FFFF;
            p = ua / ub;
            return p[31:0];
         end
         3'b110: begin
            if (b == 0) return a;
            p = sa % sb;
            return p[31:0];
         end
         default: begin
            if (b == 0) return a;
            p = ua % ub;
            return p[31:0];
         end
      endcase
   endfunction

   function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      if (!f[2] || b == 0) return 2;
      if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
      return 35;
   endfunction

   // Entered just after a rising edge with the DUT idle; returns the same way.
   task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string name);
      int lat;
      int want_lat;
      bit busy_ok;
      want_lat = ref_lat(f, a, b);
      funct3 = f;
      rs1    = a;
      rs2    = b;
      start  = 1'b1;
      exp_q.push_back(exp);
      @(negedge clock);
      busy_ok = (busy === 1'b1);
      @(posedge clock);
      #1;
      start  = 1'b0;
      funct3 = 3'($urandom);
      rs1    = $urandom;
      rs2    = $urandom;
      lat    = 0;
      forever begin
         @(negedge clock);
         lat++;
         if (done === 1'b1) break;
         if (busy !== 1'b1) busy_ok = 1'b0;
         if (lat >= 40) break;
      end
      if (done === 1'b1) begin
         if (busy !== 1'b0) busy_ok = 1'b0;
         check({name, " result"}, result, exp_q.pop_front());
      end else begin
         n_vec++;
         n_bad++;
         $display("FAIL %s timeout: no done within %0d cycles, want 0x%08h", name, lat,
                  exp_q.pop_front());
      end
      check({name, " latency"}, 32'(lat), 32'(want_lat));
      check({name, " busy"}, {31'b0, busy_ok}, 32'd1);
      @(posedge clock);
      #1;
   endtask

   initial begin
      logic [2:0]  f;
      logic [31:0] a, b;
      logic [4:0]  done_pat, busy_pat;
      int          ndone;

      tbl.push_back('{FUNCT3_MUL,    32'd7,           32'hFFFF_FFFD, 32'hFFFF_FFEB});
      tbl.push_back('{FUNCT3_MULH,   32'h8000_0000,   32'hFFFF_FFFF, 32'h0000_0000});
      tbl.push_back('{FUNCT3_MULHSU, 32'h8000_0000,   32'hFFFF_FFFF, 32'h8000_0000});
      tbl.push_back('{FUNCT3_MULHU,  32'h8000_0000,   32'hFFFF_FFFF, 32'h7FFF_FFFF});
      tbl.push_back('{FUNCT3_MULHU,  32'hFFFF_FFFF,   32'hFFFF_FFFF, 32'hFFFF_FFFE});
      tbl.push_back('{FUNCT3_MUL,    32'hFFFF_FFFF,   32'hFFFF_FFFF, 32'h0000_0001});
      tbl.push_back('{FUNCT3_DIV,    32'hFFFF_FFEC,   32'd6,         32'hFFFF_FFFD});
      tbl.push_back('{FUNCT3_REM,    32'hFFFF_FFEC,   32'd6,         32'hFFFF_FFFE});
      tbl.push_back('{FUNCT3_DIVU,   32'd20,          32'd6,         32'd3});
      tbl.push_back('{FUNCT3_DIV,    32'd20,          32'hFFFF_FFFA, 32'hFFFF_FFFD});
      tbl.push_back('{FUNCT3_REM,    32'd20,          32'hFFFF_FFFA, 32'd2});
      tbl.push_back('{FUNCT3_REM,    32'hFFFF_FFEC,   32'hFFFF_FFFA, 32'hFFFF_FFFE});
      tbl.push_back('{FUNCT3_REMU,   32'd100,         32'd7,         32'd2});
      tbl.push_back('{FUNCT3_DIVU,   32'hFFFF_FFFF,   32'd1,         32'hFFFF_FFFF});
      tbl.push_back('{FUNCT3_DIV,    32'd123,         32'd0,         32'hFFFF_FFFF});
      tbl.push_back('{FUNCT3_DIVU,   32'd5,           32'd0,         32'hFFFF_FFFF});
      tbl.push_back('{FUNCT3_REMU,   32'd5,           32'd0,         32'd5});
      tbl.push_back('{FUNCT3_REM,    32'hFFFF_FFF9,   32'd0,         32'hFFFF_FFF9});
      tbl.push_back('{FUNCT3_DIV,    32'h8000_0000,   32'hFFFF_FFFF, 32'h8000_0000});
      tbl.push_back('{FUNCT3_REM,    32'h8000_0000,   32'hFFFF_FFFF, 32'h0000_0000});

      // Reset state
      @(negedge clock);
      check("reset busy", {31'b0, busy}, 32'd0);
      check("reset done", {31'b0, done}, 32'd0);
      check("reset result", result, 32'd0);
      @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock);
      #1;

      foreach (tbl[i]) run_op(tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].r, $sformatf("vec%0d", i));

      // Flush during iteration 10 of a DIV
      run_op(FUNCT3_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "pre-flush mul");
      funct3 = FUNCT3_DIV;
      rs1    = 32'hFFFF_FFEC;
      rs2    = 32'd6;
      start  = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      repeat (11) @(posedge clock);
      #1;
      flush = 1'b1;
      @(negedge clock);
      check("flush iter busy", {31'b0, busy}, 32'd1);
      @(posedge clock);
      #1;
      flush = 1'b0;
      @(negedge clock);
      check("post-flush busy", {31'b0, busy}, 32'd0);
      check("post-flush done", {31'b0, done}, 32'd0);
      check("post-flush result", result, 32'hFFFF_FFEB);
      @(posedge clock);
      #1;
      run_op(FUNCT3_MUL, 32'd9, 32'd5, 32'd45, "mul after flush");

      // start coincident with flush is dropped
      funct3 = FUNCT3_MUL;
      rs1    = 32'd3;
      rs2    = 32'd3;
      start  = 1'b1;
      flush  = 1'b1;
      @(negedge clock);
      check("start+flush busy", {31'b0, busy}, 32'd0);
      @(posedge clock);
      #1;
      start = 1'b0;
      flush = 1'b0;
      ndone = 0;
      repeat (4) begin
         @(negedge clock);
         if (done === 1'b1) ndone++;
         if (busy !== 1'b0) ndone += 100;
      end
      check("start+flush dropped", 32'(ndone), 32'd0);
      check("start+flush result", result, 32'd45);
      @(posedge clock);
      #1;

      // Asynchronous reset in the middle of DIV_ITER
      funct3 = FUNCT3_DIVU;
      rs1    = 32'd1000;
      rs2    = 32'd7;
      start  = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      repeat (8) @(posedge clock);
      @(negedge clock);
      check("pre-reset busy", {31'b0, busy}, 32'd1);
      #2;
      reset = 1'b0;
      #1;
      check("async reset busy", {31'b0, busy}, 32'd0);
      check("async reset done", {31'b0, done}, 32'd0);
      check("async reset result", result, 32'd0);
      @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock);
      #1;

      // start held high across DONE: re-accepted only from IDLE
      funct3 = FUNCT3_MUL;
      rs1    = 32'd7;
      rs2    = 32'hFFFF_FFFD;
      start  = 1'b1;
      @(posedge clock);
      #1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clock);
         done_pat[c] = done;
         busy_pat[c] = busy;
         if (c == 4) start = 1'b0;
      end
      check("held start done pattern", {27'b0, done_pat}, 32'b10010);
      check("held start busy pattern", {27'b0, busy_pat}, 32'b01101);
      check("held start result", result, 32'hFFFF_FFEB);
      @(posedge clock);
      #1;

      // Random operations against the reference model
      for (int n = 0; n < 1200; n++) begin
         f = 3'($urandom);
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: begin a = 32'($urandom_range(0, 255)); b = 32'($urandom_range(1, 15)); end
            3: b = {{24{b[7]}}, b[7:0]};
            default: ;
         endcase
         run_op(f, a, b, ref_res(f, a, b), $sformatf("rnd%0d f%0d", n, f));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
